memory_refill_arbiter: RTL and testbench



---
 rtl/memory_refill_arbiter_pkg.sv | 19 +
 rtl/memory_refill_arbiter_tag_table.sv | 58 +++++
 rtl/memory_refill_arbiter.sv | 120 ++++++++++++
 tb/tb_memory_refill_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_refill_arbiter_pkg.sv
// Shared memory-system constants and types for the refill arbiter.
// Widths derive from the micro-architecture configuration below.
package memory_refill_arbiter_pkg;

  localparam int CONF_DCACHE_MSHR_NUM      = 2;
  localparam int CONF_DCACHE_LINE_BYTE_NUM = 8;
  localparam int CONF_MEM_TAG_NUM          = 4;

  localparam int REFILL_REQ_NUM    = 1 + CONF_DCACHE_MSHR_NUM;
  localparam int REFILL_LINE_WIDTH = CONF_DCACHE_LINE_BYTE_NUM * 8;
  localparam int REFILL_TAG_NUM    = CONF_MEM_TAG_NUM;

  localparam int REFILL_TAG_WIDTH    = (REFILL_TAG_NUM > 1) ? $clog2(REFILL_TAG_NUM) : 1;
  localparam int REFILL_REQ_ID_WIDTH = (REFILL_REQ_NUM > 1) ? $clog2(REFILL_REQ_NUM) : 1;

  typedef logic [REFILL_REQ_ID_WIDTH-1:0] req_id_path_t;
  typedef logic [REFILL_TAG_WIDTH-1:0]    mem_tag_path_t;

endpackage

// File: rtl/memory_refill_arbiter_tag_table.sv
// Outstanding-read tag table: free bitmap plus owning requester per tag.
// Allocation picks the lowest free tag; frees become visible next cycle.
module refill_tag_table
  import memory_refill_arbiter_pkg::*;
#(
  parameter int TAG_NUM = REFILL_TAG_NUM,
  parameter int REQ_NUM = REFILL_REQ_NUM,
  localparam int TW = (TAG_NUM > 1) ? $clog2(TAG_NUM) : 1,
  localparam int RW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc,
  input  logic [RW-1:0] alloc_owner,
  input  logic          free_valid,
  input  logic [TW-1:0] free_tag,
  input  logic [TW-1:0] lookup_tag,
  output logic          any_free,
  output logic [TW-1:0] alloc_tag,
  output logic          lookup_in_use,
  output logic [RW-1:0] lookup_owner
);

  logic [TAG_NUM-1:0] free_map;
  logic [RW-1:0]      owner [TAG_NUM];

  always_comb begin
    logic found;
    found     = 1'b0;
    alloc_tag = '0;
    for (int t = 0; t < TAG_NUM; t++) begin
      if (free_map[t] && !found) begin
        found     = 1'b1;
        alloc_tag = TW'(t);
      end
    end
  end

  assign any_free      = |free_map;
  assign lookup_in_use = (int'(lookup_tag) < TAG_NUM) && !free_map[lookup_tag];
  assign lookup_owner  = owner[lookup_tag];

  // Alloc and free never target the same tag: alloc only takes free tags,
  // and the parent frees only tags that are in use.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_map <= '1;
      for (int t = 0; t < TAG_NUM; t++) owner[t] <= '0;
    end else begin
      if (alloc) begin
        free_map[alloc_tag] <= 1'b0;
        owner[alloc_tag]    <= alloc_owner;
      end
      if (free_valid) free_map[free_tag] <= 1'b1;
    end
  end

endmodule

// File: rtl/memory_refill_arbiter.sv
// Round-robin arbiter merging I-cache and MSHR line requests onto one memory port,
// tagging refill reads and routing tagged responses back to their owners.
module memory_refill_arbiter
  import memory_refill_arbiter_pkg::*;
#(
  parameter int REQ_NUM    = REFILL_REQ_NUM,
  parameter int LINE_WIDTH = REFILL_LINE_WIDTH,
  parameter int TAG_NUM    = REFILL_TAG_NUM,
  localparam int TAG_WIDTH = (TAG_NUM > 1) ? $clog2(TAG_NUM) : 1,
  localparam int RW        = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_NUM-1:0]            reqValid,
  input  logic [REQ_NUM*32-1:0]         reqAddr,
  input  logic [REQ_NUM-1:0]            reqIsWrite,
  input  logic [REQ_NUM*LINE_WIDTH-1:0] reqData,
  output logic [REQ_NUM-1:0]            reqGrant,
  output logic                          memReqValid,
  output logic [31:0]                   memReqAddr,
  output logic                          memReqIsWrite,
  output logic [LINE_WIDTH-1:0]         memReqData,
  output logic [TAG_WIDTH-1:0]          memReqTag,
  input  logic                          memReqReady,
  input  logic                          memRespValid,
  input  logic [TAG_WIDTH-1:0]          memRespTag,
  input  logic [LINE_WIDTH-1:0]         memRespData,
  output logic [REQ_NUM-1:0]            respValid,
  output logic [LINE_WIDTH-1:0]         respData,
  output logic                          tagError
);

  // Handshakes: a requester holds reqValid (and its fields) until it sees
  // reqGrant in the same cycle; the memory side transfers on
  // memReqValid & memReqReady and memReq* stay stable until that happens.

  logic [RW-1:0]        rr_ptr;
  logic                 can_load;
  logic                 grant_found;
  logic [RW-1:0]        grant_idx;
  logic                 grant_is_write;
  logic                 tag_any_free;
  logic [TAG_WIDTH-1:0] tag_alloc;
  logic                 tag_in_use;
  logic [RW-1:0]        tag_owner;
  logic                 resp_hit;

  refill_tag_table #(
    .TAG_NUM (TAG_NUM),
    .REQ_NUM (REQ_NUM)
  ) u_tag_table (
    .clk           (clk),
    .rst           (rst),
    .alloc         (grant_found && !grant_is_write),
    .alloc_owner   (grant_idx),
    .free_valid    (resp_hit),
    .free_tag      (memRespTag),
    .lookup_tag    (memRespTag),
    .any_free      (tag_any_free),
    .alloc_tag     (tag_alloc),
    .lookup_in_use (tag_in_use),
    .lookup_owner  (tag_owner)
  );

  assign resp_hit = memRespValid && tag_in_use;

  always_comb begin
    int idx;
    idx         = 0;
    can_load    = !memReqValid || memReqReady;
    grant_found = 1'b0;
    grant_idx   = '0;
    reqGrant    = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (!grant_found && can_load && !rst && reqValid[idx] &&
          (reqIsWrite[idx] || tag_any_free)) begin
        grant_found = 1'b1;
        grant_idx   = RW'(idx);
      end
    end
    grant_is_write = reqIsWrite[grant_idx];
    if (grant_found) reqGrant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= '0;
      memReqValid   <= 1'b0;
      memReqAddr    <= '0;
      memReqIsWrite <= 1'b0;
      memReqData    <= '0;
      memReqTag     <= '0;
      respValid     <= '0;
      respData      <= '0;
      tagError      <= 1'b0;
    end else begin
      if (grant_found) begin
        memReqValid   <= 1'b1;
        memReqAddr    <= reqAddr[int'(grant_idx)*32 +: 32];
        memReqIsWrite <= grant_is_write;
        memReqData    <= reqData[int'(grant_idx)*LINE_WIDTH +: LINE_WIDTH];
        memReqTag     <= grant_is_write ? '0 : tag_alloc;
        rr_ptr        <= (int'(grant_idx) == REQ_NUM - 1) ? '0 : RW'(int'(grant_idx) + 1);
      end else if (memReqReady) begin
        memReqValid <= 1'b0;
      end

      // Responses are independent of the grant path in the same cycle.
      respValid <= '0;
      if (resp_hit) begin
        respValid[tag_owner] <= 1'b1;
        respData             <= memRespData;
      end
      if (memRespValid && !tag_in_use) tagError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_refill_arbiter.sv
// Directed bench for memory_refill_arbiter: a cycle table from reset plus
// hand-written sequences for back-pressure and mid-transaction reset.
module tb_memory_refill_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   reqValid;
  logic [95:0]  reqAddr;
  logic [2:0]   reqIsWrite;
  logic [191:0] reqData;
  logic [2:0]   reqGrant;
  logic         memReqValid;
  logic [31:0]  memReqAddr;
  logic         memReqIsWrite;
  logic [63:0]  memReqData;
  logic [1:0]   memReqTag;
  logic         memReqReady;
  logic         memRespValid;
  logic [1:0]   memRespTag;
  logic [63:0]  memRespData;
  logic [2:0]   respValid;
  logic [63:0]  respData;
  logic         tagError;

  int n_checks = 0;
  int n_fail   = 0;

  memory_refill_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .reqValid      (reqValid),
    .reqAddr       (reqAddr),
    .reqIsWrite    (reqIsWrite),
    .reqData       (reqData),
    .reqGrant      (reqGrant),
    .memReqValid   (memReqValid),
    .memReqAddr    (memReqAddr),
    .memReqIsWrite (memReqIsWrite),
    .memReqData    (memReqData),
    .memReqTag     (memReqTag),
    .memReqReady   (memReqReady),
    .memRespValid  (memRespValid),
    .memRespTag    (memRespTag),
    .memRespData   (memRespData),
    .respValid     (respValid),
    .respData      (respData),
    .tagError      (tagError)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [95:0]  ADDRS = {32'h0000_2040, 32'h0000_0140, 32'h0000_0100};
  localparam logic [191:0] DATAS = {64'hC2C2_0000_0000_0002, 64'hC1C1_0000_0000_0001,
                                    64'hC0C0_0000_0000_0000};

  function automatic logic [63:0] rsp_data(input logic [1:0] t);
    return 64'hDEAD_0000_0000_0000 | {62'd0, t};
  endfunction

  typedef struct {
    logic [2:0]  rv;
    logic [2:0]  rw;
    logic        rdy;
    logic        sv;
    logic [1:0]  st;
    logic [2:0]  e_grant;
    logic        e_mv;
    logic [31:0] e_addr;
    logic        e_mw;
    logic [1:0]  e_mtag;
    logic [2:0]  e_rv;
    logic [63:0] e_rdata;
    logic        e_terr;
  } vec_t;

  vec_t vecs [14];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] rv, input logic [2:0] rw, input logic rdy,
                       input logic sv, input logic [1:0] st);
    reqValid     = rv;
    reqIsWrite   = rw;
    memReqReady  = rdy;
    memRespValid = sv;
    memRespTag   = st;
    memRespData  = rsp_data(st);
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, " memReqValid"}, 64'(memReqValid), 64'd0);
    chk({pfx, " memReqAddr"},  64'(memReqAddr),  64'd0);
    chk({pfx, " memReqTag"},   64'(memReqTag),   64'd0);
    chk({pfx, " memReqData"},  memReqData,       64'd0);
    chk({pfx, " respValid"},   64'(respValid),   64'd0);
    chk({pfx, " respData"},    respData,         64'd0);
    chk({pfx, " tagError"},    64'(tagError),    64'd0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    reqAddr = ADDRS;
    reqData = DATAS;
    drive(3'b000, 3'b000, 1'b1, 1'b0, 2'd0);
    tick();
    @(negedge clk);
    chk("reset reqGrant", 64'(reqGrant), 64'd0);
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
  endtask

  initial begin
    //           rv      rw      rdy   sv    st      grant   mv    addr           mw    mtag   rv_out  rdata           terr
    vecs[0]  = '{3'b111, 3'b000, 1'b1, 1'b0, 2'd0, 3'b001, 1'b0, 32'h0,       1'b0, 2'd0, 3'b000, 64'h0,          1'b0};
    vecs[1]  = '{3'b110, 3'b000, 1'b1, 1'b0, 2'd0, 3'b010, 1'b1, 32'h100,     1'b0, 2'd0, 3'b000, 64'h0,          1'b0};
    vecs[2]  = '{3'b100, 3'b000, 1'b1, 1'b0, 2'd0, 3'b100, 1'b1, 32'h140,     1'b0, 2'd1, 3'b000, 64'h0,          1'b0};
    vecs[3]  = '{3'b010, 3'b000, 1'b1, 1'b0, 2'd0, 3'b010, 1'b1, 32'h2040,    1'b0, 2'd2, 3'b000, 64'h0,          1'b0};
    vecs[4]  = '{3'b010, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b1, 32'h140,     1'b0, 2'd3, 3'b000, 64'h0,          1'b0};
    vecs[5]  = '{3'b110, 3'b100, 1'b1, 1'b0, 2'd0, 3'b100, 1'b0, 32'h0,       1'b0, 2'd0, 3'b000, 64'h0,          1'b0};
    vecs[6]  = '{3'b010, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b1, 32'h2040,    1'b1, 2'd0, 3'b000, 64'h0,          1'b0};
    vecs[7]  = '{3'b010, 3'b000, 1'b1, 1'b1, 2'd2, 3'b000, 1'b0, 32'h0,       1'b0, 2'd0, 3'b000, 64'h0,          1'b0};
    vecs[8]  = '{3'b010, 3'b000, 1'b1, 1'b0, 2'd0, 3'b010, 1'b0, 32'h0,       1'b0, 2'd0, 3'b100, rsp_data(2'd2), 1'b0};
    vecs[9]  = '{3'b000, 3'b000, 1'b1, 1'b1, 2'd0, 3'b000, 1'b1, 32'h140,     1'b0, 2'd2, 3'b000, 64'h0,          1'b0};
    vecs[10] = '{3'b000, 3'b000, 1'b1, 1'b1, 2'd0, 3'b000, 1'b0, 32'h0,       1'b0, 2'd0, 3'b001, rsp_data(2'd0), 1'b0};
    vecs[11] = '{3'b000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 32'h0,       1'b0, 2'd0, 3'b000, 64'h0,          1'b1};
    vecs[12] = '{3'b001, 3'b000, 1'b1, 1'b1, 2'd2, 3'b001, 1'b0, 32'h0,       1'b0, 2'd0, 3'b000, 64'h0,          1'b1};
    vecs[13] = '{3'b000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 1'b1, 32'h100,     1'b0, 2'd0, 3'b010, rsp_data(2'd2), 1'b1};

    // Table run: round-robin fill, tag exhaustion, write bypass, response routing, stray tag.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rv, vecs[i].rw, vecs[i].rdy, vecs[i].sv, vecs[i].st);
      @(negedge clk);
      chk($sformatf("row%0d reqGrant", i), 64'(reqGrant), 64'(vecs[i].e_grant));
      chk($sformatf("row%0d memReqValid", i), 64'(memReqValid), 64'(vecs[i].e_mv));
      if (vecs[i].e_mv) begin
        chk($sformatf("row%0d memReqAddr", i), 64'(memReqAddr), 64'(vecs[i].e_addr));
        chk($sformatf("row%0d memReqIsWrite", i), 64'(memReqIsWrite), 64'(vecs[i].e_mw));
        chk($sformatf("row%0d memReqTag", i), 64'(memReqTag), 64'(vecs[i].e_mtag));
      end
      chk($sformatf("row%0d respValid", i), 64'(respValid), 64'(vecs[i].e_rv));
      if (vecs[i].e_rv != 3'b000)
        chk($sformatf("row%0d respData", i), respData, vecs[i].e_rdata);
      chk($sformatf("row%0d tagError", i), 64'(tagError), 64'(vecs[i].e_terr));
      tick();
    end

    // Back-pressure: request at 0x1000 held while memReqReady is low.
    do_reset();
    reqAddr[31:0] = 32'h0000_1000;
    drive(3'b001, 3'b000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    chk("bp first grant", 64'(reqGrant), 64'd1);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(3'b010, 3'b000, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      chk($sformatf("bp stall%0d reqGrant", c), 64'(reqGrant), 64'd0);
      chk($sformatf("bp stall%0d memReqValid", c), 64'(memReqValid), 64'd1);
      chk($sformatf("bp stall%0d memReqAddr", c), 64'(memReqAddr), 64'h1000);
      chk($sformatf("bp stall%0d memReqTag", c), 64'(memReqTag), 64'd0);
      chk($sformatf("bp stall%0d memReqData", c), memReqData, DATAS[63:0]);
      tick();
    end
    drive(3'b010, 3'b000, 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    chk("bp drain reqGrant", 64'(reqGrant), 64'b010);
    chk("bp drain memReqAddr", 64'(memReqAddr), 64'h1000);
    tick();
    drive(3'b000, 3'b000, 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    chk("bp next memReqValid", 64'(memReqValid), 64'd1);
    chk("bp next memReqAddr", 64'(memReqAddr), 64'h140);
    chk("bp next memReqTag", 64'(memReqTag), 64'd1);
    chk("bp next memReqData", memReqData, DATAS[127:64]);
    tick();

    // Reset with two tags outstanding and a pending memory request.
    do_reset();
    drive(3'b011, 3'b000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    chk("mr grant0", 64'(reqGrant), 64'b001);
    tick();
    drive(3'b010, 3'b000, 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    chk("mr grant1", 64'(reqGrant), 64'b010);
    tick();
    drive(3'b000, 3'b000, 1'b0, 1'b1, 2'd0);
    @(negedge clk);
    chk("mr memReqTag", 64'(memReqTag), 64'd1);
    tick();
    rst = 1'b1;
    drive(3'b100, 3'b000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    chk("mr reqGrant in rst", 64'(reqGrant), 64'd0);
    chk("mr respValid pre", 64'(respValid), 64'b001);
    chk("mr respData pre", respData, rsp_data(2'd0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mr after rst");
    chk("mr new grant", 64'(reqGrant), 64'b100);
    tick();
    drive(3'b000, 3'b000, 1'b1, 1'b1, 2'd1);
    @(negedge clk);
    chk("mr new memReqValid", 64'(memReqValid), 64'd1);
    chk("mr new memReqAddr", 64'(memReqAddr), 64'h2040);
    chk("mr new memReqTag", 64'(memReqTag), 64'd0);
    tick();
    drive(3'b000, 3'b000, 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    chk("mr stale respValid", 64'(respValid), 64'd0);
    chk("mr stale tagError", 64'(tagError), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
